// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller for the asynchronous FIFO.
// Owns binary/Gray read pointers, RAM read address and fill status.
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int AE_THRESH  = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH:0]   i_wptr_gray_sync,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic [ADDR_WIDTH:0]   o_rptr_gray,
   output logic                  o_empty,
   output logic                  o_almost_empty,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_underflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

   logic [PW-1:0] rbin_q, rbin_d;
   logic [PW-1:0] rgray_q, rgray_d;
   logic [PW-1:0] count_q, count_d;
   logic [PW-1:0] wbin;
   logic          empty_q, empty_d;
   logic          ae_q, ae_d;
   logic          uf_q, uf_d;
   logic          accept;

   // Gray-to-binary of the synchronized write pointer (XOR prefix from MSB)
   always_comb begin
      wbin = '0;
      for (int i = 0; i < PW; i++) begin
         wbin[i] = ^(i_wptr_gray_sync >> i);
      end
   end

   // Next-state: pointer advance, Gray encode and status from new pointer
   always_comb begin
      accept  = i_rd_en & ~empty_q;
      rbin_d  = rbin_q + PW'(accept);
      rgray_d = rbin_d ^ (rbin_d >> 1);
      empty_d = (rgray_d == i_wptr_gray_sync);
      count_d = wbin - rbin_d;
      ae_d    = (count_d <= AE_T);
      uf_d    = i_rd_en & empty_q;
   end

   // State and registered outputs, async active-low reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rbin_q  <= '0;
         rgray_q <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         ae_q    <= 1'b1;
         uf_q    <= 1'b0;
      end else begin
         rbin_q  <= rbin_d;
         rgray_q <= rgray_d;
         count_q <= count_d;
         empty_q <= empty_d;
         ae_q    <= ae_d;
         uf_q    <= uf_d;
      end
   end

   assign o_rd_addr      = rbin_q[ADDR_WIDTH-1:0];
   assign o_rptr_gray    = rgray_q;
   assign o_empty        = empty_q;
   assign o_almost_empty = ae_q;
   assign o_count        = count_q;
   assign o_underflow    = uf_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Testbench for fifo_rd_ctrl.
// Directed plan steps plus random traffic against an arithmetic model.
module tb_fifo_rd_ctrl;

   logic       clk;
   logic       i_rst_n;
   logic       i_rd_en;
   logic [4:0] i_wptr_gray_sync;
   logic [3:0] o_rd_addr;
   logic [4:0] o_rptr_gray;
   logic       o_empty;
   logic       o_almost_empty;
   logic [4:0] o_count;
   logic       o_underflow;

   int n_chk;
   int n_fail;

   // model state: plain integer pointers, status from arithmetic
   int m_rbin;
   int m_wb;
   int m_cnt;
   bit m_empty;
   bit m_ae;
   bit m_uf;

   fifo_rd_ctrl #(.ADDR_WIDTH(4), .AE_THRESH(2)) dut (
      .i_clk            (clk),
      .i_rst_n          (i_rst_n),
      .i_rd_en          (i_rd_en),
      .i_wptr_gray_sync (i_wptr_gray_sync),
      .o_rd_addr        (o_rd_addr),
      .o_rptr_gray      (o_rptr_gray),
      .o_empty          (o_empty),
      .o_almost_empty   (o_almost_empty),
      .o_count          (o_count),
      .o_underflow      (o_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] gray5(input int b);
      logic [4:0] v;
      v = b[4:0];
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".addr"}, 32'(o_rd_addr), 32'(m_rbin % 16));
      chk({tag, ".gray"}, 32'(o_rptr_gray), 32'(gray5(m_rbin)));
      chk({tag, ".empty"}, 32'(o_empty), 32'(m_empty));
      chk({tag, ".ae"}, 32'(o_almost_empty), 32'(m_ae));
      chk({tag, ".count"}, 32'(o_count), 32'(m_cnt));
      chk({tag, ".uf"}, 32'(o_underflow), 32'(m_uf));
   endtask

   task automatic model_reset();
      m_rbin  = 0;
      m_cnt   = 0;
      m_empty = 1'b1;
      m_ae    = 1'b1;
      m_uf    = 1'b0;
   endtask

   // async reset: checked before any clock edge can occur
   task automatic do_reset(input string tag);
      i_rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      @(negedge clk);
      i_rst_n = 1'b1;
   endtask

   // one cycle: drive inputs, step the model, check after the edge
   task automatic cyc(input bit rd, input int wb, input string tag);
      bit acc;
      i_rd_en = rd;
      m_wb = wb % 32;
      i_wptr_gray_sync = gray5(m_wb);
      @(posedge clk);
      acc     = rd && !m_empty;
      m_uf    = rd && m_empty;
      m_rbin  = (m_rbin + int'(acc)) % 32;
      m_cnt   = (m_wb - m_rbin + 32) % 32;
      m_empty = (m_cnt == 0);
      m_ae    = (m_cnt <= 2);
      #1;
      check_all(tag);
   endtask

   initial begin
      int room;
      int adv;
      n_chk = 0;
      n_fail = 0;
      m_wb = 0;
      i_rst_n = 1'b1;
      i_rd_en = 1'b0;
      i_wptr_gray_sync = 5'b00000;
      #2;
      do_reset("rst0");

      // basic read of three words, then underflow
      cyc(0, 3, "basic.load");
      for (int i = 0; i < 3; i++) cyc(1, 3, "basic.rd");
      cyc(1, 3, "uf1");
      cyc(1, 3, "uf2");
      cyc(0, 3, "uf.idle");

      // full FIFO from reset, drain with address wrap
      do_reset("rst1");
      cyc(0, 16, "full.load");
      for (int i = 0; i < 16; i++) cyc(1, 16, "full.rd");

      // pointer wrap 31 -> 0
      cyc(0, 30, "wrap.load");
      for (int i = 0; i < 14; i++) cyc(1, 30, "wrap.pre");
      cyc(0, 31, "wrap.w31");
      cyc(0, 0, "wrap.w0");
      cyc(1, 0, "wrap.rd1");
      cyc(1, 0, "wrap.rd2");

      // simultaneous write jump and read
      do_reset("rst2");
      cyc(0, 3, "sim.load");
      cyc(1, 5, "sim.both");
      cyc(0, 6, "mid.load");

      // mid-stream reset with count 5
      do_reset("rst.mid");

      // random traffic with legal write-pointer motion
      for (int i = 0; i < 400; i++) begin
         room = 16 - ((m_wb - m_rbin + 32) % 32);
         if (room > 3) room = 3;
         adv = int'($urandom_range(0, room));
         cyc(bit'($urandom_range(0, 1)), m_wb + adv, "rand");
         if (i == 200) do_reset("rst.rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
